// File: rtl/multicycle_datapath.sv
// ---------------------------------------------------------------------------
// multicycle_datapath
//
// Multicycle CPU core. A single FSM steps each instruction through
// FETCH -> DECODE -> EXEC (-> MEM) and back to FETCH. One memory port is
// shared by instruction fetch and LDR/STR. It uses a req/ack handshake, so
// memory latency can vary. HALT parks the core until reset.
//
// Optional feature:
//   MULTICYCLE_DATAPATH_MUL_EN  - when defined, opcode 9 is MUL
//                                 (rd = low WIDTH bits of rn*rm).
//                                 When undefined, opcode 9 is a NOP and no
//                                 multiplier is built.
//
// Parameters:
//   WIDTH    data / register / memory word width (>= 16)
//   ADDR_W   memory address and PC width
//   NREGS    architectural registers (8 or 16). Index >= NREGS reads 0, write ignored.
//   PC_STEP  PC increment per instruction, in address units
//   RESET_PC PC value after reset
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   mem_req    memory request, held until mem_ack is sampled
//   mem_we     1 = store, 0 = read (fetch or LDR)
//   mem_addr   request address
//   mem_wdata  store data
//   mem_rdata  read data, valid in the cycle mem_ack = 1
//   mem_ack    completes the request on the same rising edge
//   pc         current PC
//   alu_flags  {N,Z,C,V}
//   retire     one-cycle pulse per completed instruction. It is registered,
//              so it is high in the cycle after the completing edge.
//   halted     high while in HALT
//
// Instruction word = mem_rdata[15:0]:
//   op[15:12] rd[11:8] rn[7:4] rm/imm4[3:0]; imm8 = [7:0]
// ---------------------------------------------------------------------------
module multicycle_datapath #(
  parameter int                WIDTH    = 32,
  parameter int                ADDR_W   = 32,
  parameter int                NREGS    = 16,
  parameter int                PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        alu_flags,
  output logic              retire,
  output logic              halted
);

  localparam int RIDX = $clog2(NREGS);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_ORR  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LDR  = 4'h5;
  localparam logic [3:0] OP_STR  = 4'h6;
  localparam logic [3:0] OP_B    = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
`ifdef MULTICYCLE_DATAPATH_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'h9;
`endif
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic [15:0]         instr_reg;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [WIDTH-1:0]    d_reg;
  logic [3:0]          flags_reg;
  logic                mem_req_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [WIDTH-1:0]    mem_wdata_reg;
  logic                retire_reg;
  logic                halted_reg;

  // Instruction fields
  logic [3:0]          f_op;
  logic [3:0]          f_rd;
  logic [3:0]          f_rn;
  logic [3:0]          f_rm;
  logic signed [7:0]   f_imm8;

  assign f_op   = instr_reg[15:12];
  assign f_rd   = instr_reg[11:8];
  assign f_rn   = instr_reg[7:4];
  assign f_rm   = instr_reg[3:0];
  assign f_imm8 = instr_reg[7:0];

  // -------------------------------------------------------------------------
  // Register file: one flop bank per register. A write whose rd is outside
  // 0..NREGS-1 matches no bank, so it is dropped.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0]    rf [NREGS];
  logic                rf_we;
  logic [WIDTH-1:0]    rf_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_rf
      logic [WIDTH-1:0] q_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_reg <= '0;
        end else if (rf_we && (f_rd == 4'(gi))) begin
          q_reg <= rf_wdata;
        end
      end

      assign rf[gi] = q_reg;
    end
  endgenerate

  // Read ports. An out-of-range index reads as zero.
  logic [WIDTH-1:0] rn_val;
  logic [WIDTH-1:0] rm_val;
  logic [WIDTH-1:0] rd_val;

  always_comb begin
    rn_val = '0;
    rm_val = '0;
    rd_val = '0;
    if ({1'b0, f_rn} < 5'(NREGS)) rn_val = rf[f_rn[RIDX-1:0]];
    if ({1'b0, f_rm} < 5'(NREGS)) rm_val = rf[f_rm[RIDX-1:0]];
    if ({1'b0, f_rd} < 5'(NREGS)) rd_val = rf[f_rd[RIDX-1:0]];
  end

  // ADDI/LDR/STR take the zero-extended imm4 as their B operand.
  logic uses_imm;
  assign uses_imm = (f_op == OP_ADDI) || (f_op == OP_LDR) || (f_op == OP_STR);

  // -------------------------------------------------------------------------
  // ALU
  // alu_upd marks the ops that write rd and update flags.
  // AND/ORR/MUL recompute only N and Z; they carry C and V forward.
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_upd;
  logic [3:0]       alu_flags_next;

  assign sum_ext = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff    = a_reg - b_reg;

  always_comb begin
    alu_res = '0;
    alu_c   = flags_reg[1];
    alu_v   = flags_reg[0];
    alu_upd = 1'b0;
    case (f_op)
      OP_ADD, OP_ADDI: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != a_reg[WIDTH-1]);
        alu_upd = 1'b1;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (a_reg >= b_reg);
        alu_v   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                  (diff[WIDTH-1] != a_reg[WIDTH-1]);
        alu_upd = 1'b1;
      end
      OP_AND: begin
        alu_res = a_reg & b_reg;
        alu_upd = 1'b1;
      end
      OP_ORR: begin
        alu_res = a_reg | b_reg;
        alu_upd = 1'b1;
      end
`ifdef MULTICYCLE_DATAPATH_MUL_EN
      OP_MUL: begin
        alu_res = a_reg * b_reg;
        alu_upd = 1'b1;
      end
`endif
      default: ;
    endcase
    alu_flags_next = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
  end

  // -------------------------------------------------------------------------
  // PC arithmetic. It wraps modulo 2^ADDR_W.
  // The branch offset is sign-extended imm8 scaled by the PC step.
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_target;
  logic              br_taken;
  logic [ADDR_W-1:0] exec_pc;
  logic [ADDR_W-1:0] ls_addr;
  logic [WIDTH-1:0]  ls_sum;

  assign pc_inc    = pc_reg + STEP;
  assign br_target = pc_inc + (ADDR_W'(f_imm8) * STEP);
  assign br_taken  = (f_op == OP_B) || ((f_op == OP_BEQ) && flags_reg[2]);
  assign exec_pc   = br_taken ? br_target : pc_inc;
  // The load/store address is the WIDTH-bit sum, resized to ADDR_W.
  assign ls_sum    = sum_ext[WIDTH-1:0];
  assign ls_addr   = ADDR_W'(ls_sum);

  // Register write port.
  // - EXEC: ALU results.
  // - MEM, on ack: LDR data.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    if ((state_reg == S_EXEC) && alu_upd) begin
      rf_we = 1'b1;
    end else if ((state_reg == S_MEM) && mem_ack && (f_op == OP_LDR)) begin
      rf_we    = 1'b1;
      rf_wdata = mem_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer. Completing states raise mem_req for the next fetch on the
  // same edge, so fetch starts without a bubble. The only FETCH cycle
  // with mem_req low is the first one after reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_FETCH;
      pc_reg        <= RESET_PC;
      instr_reg     <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      d_reg         <= '0;
      flags_reg     <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= RESET_PC;
      mem_wdata_reg <= '0;
      retire_reg    <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      retire_reg <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          if (!mem_req_reg) begin
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= pc_reg;
          end else if (mem_ack) begin
            instr_reg   <= mem_rdata[15:0];
            mem_req_reg <= 1'b0;
            state_reg   <= S_DECODE;
          end
        end

        S_DECODE: begin
          a_reg     <= rn_val;
          b_reg     <= uses_imm ? WIDTH'(f_rm) : rm_val;
          d_reg     <= rd_val;
          state_reg <= S_EXEC;
        end

        S_EXEC: begin
          case (f_op)
            OP_LDR, OP_STR: begin
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= (f_op == OP_STR);
              mem_addr_reg  <= ls_addr;
              mem_wdata_reg <= d_reg;
              state_reg     <= S_MEM;
            end
            OP_HALT: begin
              retire_reg <= 1'b1;
              halted_reg <= 1'b1;
              state_reg  <= S_HALT;
            end
            default: begin
              // ALU ops, branches and NOPs all finish here.
              if (alu_upd) flags_reg <= alu_flags_next;
              pc_reg       <= exec_pc;
              mem_req_reg  <= 1'b1;
              mem_we_reg   <= 1'b0;
              mem_addr_reg <= exec_pc;
              retire_reg   <= 1'b1;
              state_reg    <= S_FETCH;
            end
          endcase
        end

        S_MEM: begin
          // Outputs stay frozen while waiting for ack.
          if (mem_ack) begin
            pc_reg       <= pc_inc;
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= pc_inc;
            retire_reg   <= 1'b1;
            state_reg    <= S_FETCH;
          end
        end

        S_HALT: ;

        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign pc        = pc_reg;
  assign alu_flags = flags_reg;
  assign retire    = retire_reg;
  assign halted    = halted_reg;

endmodule
